hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, meaning register-index width.
REQ-002 SHALL have parameter LOAD_RESULTSRC, default 2'b01, meaning the ResultSrcE code that marks a load.
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low (reset when resetn is 0, run when 1).
REQ-005 Rs1D, Rs2D  input  REG_ADDR_W  source register indices of the instruction in DECODE.
REQ-006 RdD  input  REG_ADDR_W  destination register index of the instruction in DECODE.
REQ-007 PCSrcE  input  1  taken branch or jump resolved in EXECUTE.
REQ-008 ResultSrcE  input  2  result-source select of the instruction in EXECUTE.
REQ-009 RegWriteM, RegWriteW  input  1  register-write enables in MEMORY ACCESS and WRITEBACK.
REQ-010 StallF, StallD  output  1  hold the PC register and the FETCH/DECODE pipeline register.
REQ-011 FlushD, FlushE  output  1  clear the FETCH/DECODE and DECODE/EXECUTE pipeline registers.
REQ-012 ForwardAE, ForwardBE  output  2  ALU operand source: 00 register file, 01 WRITEBACK result, 10 MEMORY ACCESS ALU result.

Function
REQ-013 SHALL hold internal shadow registers Rs1E, Rs2E, RdE, RdM, RdW, advanced every clock.
REQ-014 On each edge: Rs1E/Rs2E/RdE SHALL load 0 if FlushE=1, else Rs1D/Rs2D/RdD; RdM<=RdE; RdW<=RdM.
REQ-015 ForwardAE SHALL be 10 if RegWriteM=1 and RdM!=0 and RdM==Rs1E; else 01 if RegWriteW=1 and RdW!=0 and RdW==Rs1E; else 00.
REQ-016 ForwardBE SHALL follow REQ-015 with Rs2E in place of Rs1E; MEMORY ACCESS match SHALL win when both stages match.
REQ-017 lwStall SHALL be 1 when ResultSrcE==LOAD_RESULTSRC, RdE!=0, and RdE equals Rs1D or Rs2D.
REQ-018 StallF = StallD = lwStall and not PCSrcE.
REQ-019 FlushD = PCSrcE; FlushE = lwStall or PCSrcE.
REQ-020 Simultaneous PCSrcE and lwStall: flush SHALL win; StallF=StallD=0, FlushD=FlushE=1.
REQ-021 Register x0 SHALL never cause forwarding or stalls.
REQ-022 All outputs are combinational from shadow registers and inputs; zero-cycle latency.
REQ-023 A load-use stall SHALL last exactly one cycle: the inserted bubble clears RdE, so lwStall deasserts on the next cycle.

Reset
REQ-024 resetn=0 SHALL clear Rs1E, Rs2E, RdE, RdM, RdW to 0 immediately, without waiting for a clock edge.
REQ-025 While resetn=0, all outputs SHALL be 0 (ForwardAE=ForwardBE=00, no stall, no flush).
REQ-026 Reset asserted mid-stall SHALL drop StallF/StallD the same cycle; the first post-reset cycle sees empty shadow state.

Configuration
REQ-027 Macro HAZARD_PERF_CNT_EN defined: SHALL add outputs StallCount[31:0] and FlushCount[31:0].
REQ-028 StallCount SHALL increment on each cycle with StallD=1; FlushCount SHALL increment on each cycle with FlushD=1.
REQ-029 Both counters SHALL wrap from 0xFFFFFFFF to 0 and clear on reset.
REQ-030 Macro undefined: no counter ports or logic; behaviour otherwise identical.

Structure
REQ-031 Shared package SHALL hold the ForwardAE/ForwardBE codes (FWD_RF, FWD_WB, FWD_MEM) and the ResultSrc codes, including the load code.
REQ-032 One sub-module, hazard_fwd_sel, SHALL implement the REQ-015 priority compare and be instantiated twice (operands A and B).
REQ-033 Shadow registers SHALL use the team's existing enable/reset flop cell.

Verification
REQ-034 Scenario 1, MEM-stage forwarding: RdD=5, next cycle Rs1D=5, then RegWriteM=1 when RdM=5 -> ForwardAE=10 that cycle.
REQ-035 Scenario 2, double match: RdM=RdW=7, both write enables 1, Rs2E=7 -> ForwardBE=10, not 01.
REQ-036 Scenario 3, load-use: ResultSrcE=01, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for exactly one cycle, then 0.
REQ-037 Scenario 4, simultaneous events: load-use condition plus PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
REQ-038 Scenario 5, x0 immunity: RdM=0, RegWriteM=1, Rs1E=0 -> ForwardAE=00; load with RdE=0 and Rs1D=0 -> no stall.
REQ-039 Scenario 6, async reset: resetn pulled low between edges during a stall -> all outputs 0 before the next edge; with HAZARD_PERF_CNT_EN defined, counters read 0; a counter preloaded near 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared codes for the pipeline hazard unit.
// Holds the operand-forwarding select codes, the result-source codes
// (including the load code) and a small register-match helper.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwdSel_t;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

  // True when a destination register is non-zero and equals a source register.
  // x0 is hard-wired to zero, so it never produces a real dependency.
  function automatic logic regHit(input logic [31:0] rd, input logic [31:0] rs);
    return (rd != 32'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/dff_en_rst.sv
// dff_en_rst: enable flop with asynchronous active-low clear.
module dff_en_rst #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear immediately on reset, otherwise capture d when enabled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: forwarding source select for one ALU operand.
// The MEMORY ACCESS stage holds the younger result, so it wins over WRITEBACK.
module hazard_fwd_sel
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rsE,
  input  logic [REG_ADDR_W-1:0] rdM,
  input  logic [REG_ADDR_W-1:0] rdW,
  input  logic                  regWriteM,
  input  logic                  regWriteW,
  output logic [1:0]            forward
);

  logic [31:0] rsExt;
  logic [31:0] rdMExt;
  logic [31:0] rdWExt;

  assign rsExt  = 32'(rsE);
  assign rdMExt = 32'(rdM);
  assign rdWExt = 32'(rdW);

  // Priority compare: MEMORY ACCESS, then WRITEBACK, then register file.
  always_comb begin
    forward = FWD_RF;
    if (regWriteM && regHit(rdMExt, rsExt)) begin
      forward = FWD_MEM;
    end else if (regWriteW && regHit(rdWExt, rsExt)) begin
      forward = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: data/control hazard detection for a 5-stage pipeline.
// Tracks register indices of the EXECUTE, MEMORY ACCESS and WRITEBACK
// instructions, selects ALU operand forwarding, and raises load-use stalls
// and branch flushes. All outputs are combinational (zero-cycle latency).
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush event counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int         REG_ADDR_W     = 5,
  parameter logic [1:0] LOAD_RESULTSRC = RESULT_LOAD
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  PCSrcE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           StallCount,
  output logic [31:0]           FlushCount
`endif
);

  logic [REG_ADDR_W-1:0] Rs1E;
  logic [REG_ADDR_W-1:0] Rs2E;
  logic [REG_ADDR_W-1:0] RdE;
  logic [REG_ADDR_W-1:0] RdM;
  logic [REG_ADDR_W-1:0] RdW;

  logic [3*REG_ADDR_W-1:0] decodeNext;
  logic                    lwStall;
  logic                    flushEInt;
  logic [1:0]              fwdA;
  logic [1:0]              fwdB;

  // Load in EXECUTE whose destination is read by the DECODE instruction.
  always_comb begin
    lwStall = 1'b0;
    if (ResultSrcE == LOAD_RESULTSRC) begin
      lwStall = regHit(32'(RdE), 32'(Rs1D)) || regHit(32'(RdE), 32'(Rs2D));
    end
  end

  // A flushed EXECUTE slot becomes a bubble with all indices zero, which is
  // also what ends a load-use stall after exactly one cycle.
  assign flushEInt  = lwStall || PCSrcE;
  assign decodeNext = flushEInt ? '0 : {Rs1D, Rs2D, RdD};

  dff_en_rst #(.W(3*REG_ADDR_W)) uShadowE (
    .clk    (clk),
    .resetn (resetn),
    .en     (1'b1),
    .d      (decodeNext),
    .q      ({Rs1E, Rs2E, RdE})
  );

  dff_en_rst #(.W(REG_ADDR_W)) uShadowM (
    .clk    (clk),
    .resetn (resetn),
    .en     (1'b1),
    .d      (RdE),
    .q      (RdM)
  );

  dff_en_rst #(.W(REG_ADDR_W)) uShadowW (
    .clk    (clk),
    .resetn (resetn),
    .en     (1'b1),
    .d      (RdM),
    .q      (RdW)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) uFwdA (
    .rsE       (Rs1E),
    .rdM       (RdM),
    .rdW       (RdW),
    .regWriteM (RegWriteM),
    .regWriteW (RegWriteW),
    .forward   (fwdA)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) uFwdB (
    .rsE       (Rs2E),
    .rdM       (RdM),
    .rdW       (RdW),
    .regWriteM (RegWriteM),
    .regWriteW (RegWriteW),
    .forward   (fwdB)
  );

  // Outputs; a flush overrides a stall, and reset forces everything quiet
  // even though PCSrcE is an unregistered input.
  always_comb begin
    StallF    = resetn && lwStall && !PCSrcE;
    StallD    = resetn && lwStall && !PCSrcE;
    FlushD    = resetn && PCSrcE;
    FlushE    = resetn && flushEInt;
    ForwardAE = resetn ? fwdA : FWD_RF;
    ForwardBE = resetn ? fwdB : FWD_RF;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  // Event counters; plain binary add wraps from all-ones to zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (StallD) stallCnt <= stallCnt + 32'd1;
      if (FlushD) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign StallCount = stallCnt;
  assign FlushCount = flushCnt;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed self-checking bench for hazard_unit.
module tb_hazard_unit;

  logic       clk;
  logic       resetn;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] RdD;
  logic       PCSrcE;
  logic [1:0] ResultSrcE;
  logic       RegWriteM;
  logic       RegWriteW;
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCount;
  logic [31:0] FlushCount;
`endif

  int passCnt = 0;
  int failCnt = 0;
  int total   = 0;

  hazard_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdD        (RdD),
    .PCSrcE     (PCSrcE),
    .ResultSrcE (ResultSrcE),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount (StallCount),
    .FlushCount (FlushCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn     = 1'b0;
    Rs1D       = '0;
    Rs2D       = '0;
    RdD        = '0;
    PCSrcE     = 1'b1;
    ResultSrcE = 2'b01;
    RegWriteM  = 1'b1;
    RegWriteW  = 1'b1;
    #2;
    // reset state, with live branch/write inputs that must be masked
    chk("rst_flushD", 32'(FlushD), 0);
    chk("rst_flushE", 32'(FlushE), 0);
    chk("rst_stallF", 32'(StallF), 0);
    chk("rst_fwdA", 32'(ForwardAE), 0);
    PCSrcE = 1'b0; ResultSrcE = 2'b00; RegWriteM = 1'b0; RegWriteW = 1'b0;
    #1 resetn = 1'b1;
    tick();

    // Scenario 1: MEM then WB forwarding on operand A
    RdD = 5'd5;
    tick();                                   // RdE=5
    RdD = 5'd0; Rs1D = 5'd5;
    tick();                                   // Rs1E=5, RdM=5, RdW=0
    RegWriteM = 1'b1; #1;
    chk("s1_fwdA_mem", 32'(ForwardAE), 2);
    chk("s1_fwdB_none", 32'(ForwardBE), 0);
    RegWriteM = 1'b0; RegWriteW = 1'b1; #1;
    chk("s1_fwdA_wb_rdw0", 32'(ForwardAE), 0);
    tick();                                   // Rs1E=5, RdM=0, RdW=5
    chk("s1_fwdA_wb", 32'(ForwardAE), 1);
    RegWriteM = 1'b1; #1;
    chk("s1_fwdA_wb_rdm0", 32'(ForwardAE), 1);
    RegWriteM = 1'b0; RegWriteW = 1'b0; Rs1D = 5'd0;

    // Scenario 2: both stages match, MEM wins
    RdD = 5'd7;
    tick();                                   // RdE=7
    tick();                                   // RdE=7, RdM=7
    Rs2D = 5'd7;
    tick();                                   // Rs2E=7, RdM=7, RdW=7
    RegWriteM = 1'b1; RegWriteW = 1'b1; #1;
    chk("s2_fwdB_double", 32'(ForwardBE), 2);
    chk("s2_fwdA_none", 32'(ForwardAE), 0);
    chk("s2_no_stall", 32'(StallD), 0);
    RegWriteM = 1'b0; #1;
    chk("s2_fwdB_wb_only", 32'(ForwardBE), 1);
    RegWriteW = 1'b0; Rs2D = 5'd0; RdD = 5'd0;
    tick(); tick(); tick();

    // Scenario 3: load-use stall lasts one cycle
    RdD = 5'd3;
    tick();                                   // RdE=3
    RdD = 5'd0; Rs2D = 5'd3; ResultSrcE = 2'b01; #1;
    chk("s3_stallF", 32'(StallF), 1);
    chk("s3_stallD", 32'(StallD), 1);
    chk("s3_flushE", 32'(FlushE), 1);
    chk("s3_flushD", 32'(FlushD), 0);
    tick();                                   // bubble: RdE=0
    chk("s3_stallD_after", 32'(StallD), 0);
    chk("s3_flushE_after", 32'(FlushE), 0);

    // Scenario 4: load-use plus taken branch, flush wins
    ResultSrcE = 2'b00; RdD = 5'd3; Rs2D = 5'd3;
    tick();                                   // RdE=3, no load so no flush
    ResultSrcE = 2'b01; PCSrcE = 1'b1; #1;
    chk("s4_flushD", 32'(FlushD), 1);
    chk("s4_flushE", 32'(FlushE), 1);
    chk("s4_stallF", 32'(StallF), 0);
    chk("s4_stallD", 32'(StallD), 0);
    PCSrcE = 1'b0; #1;
    chk("s4_stall_no_branch", 32'(StallD), 1);
    ResultSrcE = 2'b00; Rs2D = 5'd0; RdD = 5'd0;
    tick(); tick(); tick();

    // Scenario 5: x0 never forwards or stalls
    RegWriteM = 1'b1; RegWriteW = 1'b1; #1;
    chk("s5_fwdA_x0", 32'(ForwardAE), 0);
    chk("s5_fwdB_x0", 32'(ForwardBE), 0);
    ResultSrcE = 2'b01; Rs1D = 5'd0; #1;
    chk("s5_no_stall_x0", 32'(StallD), 0);
    chk("s5_no_flushE_x0", 32'(FlushE), 0);
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00;

`ifdef HAZARD_PERF_CNT_EN
    // stall counter wraps from all-ones
    RdD = 5'd3;
    tick();
    RdD = 5'd0; Rs1D = 5'd3; ResultSrcE = 2'b01;
    dut.stallCnt = 32'hFFFF_FFFF;
    #1;
    tick();
    chk("cnt_stall_wrap", StallCount, 0);
    ResultSrcE = 2'b00; Rs1D = 5'd0;
    tick();
`endif

    // Scenario 6: async reset in the middle of a stall
    RdD = 5'd3;
    tick();                                   // RdE=3
    RdD = 5'd0; Rs1D = 5'd3; ResultSrcE = 2'b01; RegWriteW = 1'b1; #1;
    chk("s6_stall_before", 32'(StallF), 1);
`ifdef HAZARD_PERF_CNT_EN
    dut.flushCnt = 32'h0000_1234;
`endif
    #1 resetn = 1'b0;
    #1;
    chk("s6_rst_stallF", 32'(StallF), 0);
    chk("s6_rst_stallD", 32'(StallD), 0);
    chk("s6_rst_flushE", 32'(FlushE), 0);
    chk("s6_rst_flushD", 32'(FlushD), 0);
    chk("s6_rst_fwdA", 32'(ForwardAE), 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("s6_rst_stallcnt", StallCount, 0);
    chk("s6_rst_flushcnt", FlushCount, 0);
`endif
    #1 resetn = 1'b1;
    tick();                                   // empty shadow state loads RdE=0
    chk("s6_post_rst_stall", 32'(StallD), 0);
    chk("s6_post_rst_fwdA", 32'(ForwardAE), 0);

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end

endmodule
